// File: rtl/seq_div_pkg.sv
// ---------------------------------------------------------------------------
// seq_div_pkg
//   Shared definitions for the iterative divider:
//     - div_state_e : FSM state encoding (IDLE/RUN/FIX/DONE)
//     - div_cnt_w   : width of the iteration counter for a given operand width
//     - div_zero_quot : quotient value returned on a divide by zero
// ---------------------------------------------------------------------------
package seq_div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } div_state_e;

  // Iteration counter must hold 0..width-1.
  function automatic int div_cnt_w(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

  // Divide-by-zero quotient is all ones; the caller sizes it to WIDTH.
  localparam logic DIV_ZERO_QUOT_BIT = 1'b1;

endpackage

// File: rtl/div_negate.sv
// ---------------------------------------------------------------------------
// div_negate
//   Conditional two's-complement negator (modulo 2^WIDTH).
//   Ports:
//     val_in  [WIDTH-1:0] : value to pass through or negate
//     neg                 : 1 = output -val_in, 0 = output val_in
//     val_out [WIDTH-1:0] : result
// ---------------------------------------------------------------------------
module div_negate #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] val_in,
  input  logic             neg,
  output logic [WIDTH-1:0] val_out
);

  always_comb begin
    val_out = val_in;
    if (neg) begin
      val_out = (~val_in) + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/seq_div.sv
// ---------------------------------------------------------------------------
// seq_div
//   Iterative restoring integer divider, one quotient bit per clock.
//   Signed mode divides magnitudes and fixes signs at the end (truncating).
//   Ports:
//     clk, rst (async, active high)
//     start, is_signed, opA, opB : request, captured when busy=0
//     busy                       : high in RUN and FIX
//     done                       : one-cycle pulse, results valid from it
//     quotient, remainder        : registered, held until next accepted start
//     div_by_zero, overflow      : registered status for the last result
//   Handshake: a request is accepted on any rising edge where start=1 and
//   busy=0 (IDLE or DONE); start while busy=1 is dropped, and operands are
//   only sampled on the accepting edge.
// ---------------------------------------------------------------------------
module seq_div
  import seq_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int               CW       = div_cnt_w(WIDTH);
  localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ZQUOT    = {WIDTH{DIV_ZERO_QUOT_BIT}};

  div_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;       // dividend shifting out, quotient bits shifting in
  logic [WIDTH-1:0] rem_q, rem_d;       // partial remainder
  logic [WIDTH-1:0] dsr_q, dsr_d;       // divisor magnitude
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic             ovf_pend_q, ovf_pend_d;
  logic             dz_wait_q, dz_wait_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] a_mag, b_mag, q_fix, r_fix;
  logic [WIDTH:0]   rem_sh, trial;
  logic             a_neg, b_neg;

  assign a_neg = is_signed & opA[WIDTH-1];
  assign b_neg = is_signed & opB[WIDTH-1];

  // |MIN| comes out as 2^(WIDTH-1) read unsigned, which the loop handles.
  div_negate #(.WIDTH(WIDTH)) u_neg_a (.val_in(opA),   .neg(a_neg),   .val_out(a_mag));
  div_negate #(.WIDTH(WIDTH)) u_neg_b (.val_in(opB),   .neg(b_neg),   .val_out(b_mag));
  div_negate #(.WIDTH(WIDTH)) u_neg_q (.val_in(dvd_q), .neg(q_neg_q), .val_out(q_fix));
  div_negate #(.WIDTH(WIDTH)) u_neg_r (.val_in(rem_q), .neg(r_neg_q), .val_out(r_fix));

  // Shifted remainder can reach 2*divisor-1, so it needs WIDTH+1 bits; the
  // trial difference's top bit is then its sign.
  assign rem_sh = {rem_q, dvd_q[WIDTH-1]};
  assign trial  = rem_sh - {1'b0, dsr_q};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dvd_d       = dvd_q;
    rem_d       = rem_q;
    dsr_d       = dsr_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    ovf_pend_d  = ovf_pend_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    ovf_d       = ovf_q;
    dz_wait_d   = 1'b0;
    // A divide by zero raises done one cycle after entering DONE.
    done_d      = dz_wait_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start) begin
          dvd_d      = a_mag;
          dsr_d      = b_mag;
          rem_d      = '0;
          cnt_d      = '0;
          q_neg_d    = a_neg ^ b_neg;
          r_neg_d    = a_neg;
          ovf_pend_d = is_signed && (opA == MIN_VAL) && (opB == {WIDTH{1'b1}});
          dbz_d      = 1'b0;
          ovf_d      = 1'b0;
          if (opB == '0) begin
            quotient_d  = ZQUOT;
            remainder_d = opA;
            dbz_d       = 1'b1;
            dz_wait_d   = 1'b1;
            state_d     = ST_DONE;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (!trial[WIDTH]) begin
          rem_d = trial[WIDTH-1:0];
          dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = rem_sh[WIDTH-1:0];
          dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        quotient_d  = q_fix;
        remainder_d = r_fix;
        ovf_d       = ovf_pend_q;
        done_d      = 1'b1;
        state_d     = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      dvd_q       <= '0;
      rem_q       <= '0;
      dsr_q       <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      ovf_pend_q  <= 1'b0;
      dz_wait_q   <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dvd_q       <= dvd_d;
      rem_q       <= rem_d;
      dsr_q       <= dsr_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      ovf_pend_q  <= ovf_pend_d;
      dz_wait_q   <= dz_wait_d;
      done_q      <= done_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      ovf_q       <= ovf_d;
    end
  end

  assign busy        = (state_q == ST_RUN) || (state_q == ST_FIX);
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_seq_div.sv
module tb_seq_div;

  localparam int W = 32;

  logic         clk, rst, start, is_signed;
  logic [W-1:0] opA, opB;
  logic         busy, done, div_by_zero, overflow;
  logic [W-1:0] quotient, remainder;

  int checks   = 0;
  int failures = 0;

  seq_div #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
    .opA(opA), .opB(opB), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .overflow(overflow)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    logic         ov;
    int           lat;
    int           bcy;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive a request and return at the falling edge after the sampling edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    opA = a; opB = b; is_signed = s; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    opA = $urandom(); opB = $urandom(); is_signed = 1'($urandom_range(0, 1));
  endtask

  // Called at the falling edge after the sampling edge (cycle 1).
  task automatic wait_done(output int lat, output int bcy);
    lat = 1;
    bcy = 0;
    while (done !== 1'b1 && lat <= 100) begin
      if (busy === 1'b1) bcy++;
      @(negedge clk);
      lat++;
    end
    if (lat > 100) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: got no done, expected done within 100 cycles");
    end
  endtask

  task automatic chk_result(input string tag, input vec_t v);
    chk({tag, "_quot"}, quotient, v.q);
    chk({tag, "_rem"},  remainder, v.r);
    chk({tag, "_dz"},   W'(div_by_zero), W'(v.dz));
    chk({tag, "_ov"},   W'(overflow), W'(v.ov));
  endtask

  initial begin
    int lat, bcy;
    vec_t v;

    //        a             b             s     q             r             dz    ov    lat bcy
    vecs[0]  = '{32'd100,      32'd7,        1'b0, 32'd14,       32'd2,        1'b0, 1'b0, 34, 33};
    vecs[1]  = '{32'hFFFFFFF9, 32'd2,        1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 1'b0, 34, 33};
    vecs[2]  = '{32'd7,        32'hFFFFFFFE, 1'b1, 32'hFFFFFFFD, 32'd1,        1'b0, 1'b0, 34, 33};
    vecs[3]  = '{32'h1234,     32'd0,        1'b0, 32'hFFFFFFFF, 32'h1234,     1'b1, 1'b0, 2,  0};
    vecs[4]  = '{32'h1234,     32'd0,        1'b1, 32'hFFFFFFFF, 32'h1234,     1'b1, 1'b0, 2,  0};
    vecs[5]  = '{32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0,        1'b0, 1'b1, 34, 33};
    vecs[6]  = '{32'h80000000, 32'hFFFFFFFF, 1'b0, 32'd0,        32'h80000000, 1'b0, 1'b0, 34, 33};
    vecs[7]  = '{32'hFFFFFFFF, 32'd1,        1'b0, 32'hFFFFFFFF, 32'd0,        1'b0, 1'b0, 34, 33};
    vecs[8]  = '{32'hFFFFFF9C, 32'hFFFFFFF9, 1'b1, 32'd14,       32'hFFFFFFFE, 1'b0, 1'b0, 34, 33};
    vecs[9]  = '{32'd5,        32'd10,       1'b0, 32'd0,        32'd5,        1'b0, 1'b0, 34, 33};
    vecs[10] = '{32'd0,        32'd5,        1'b1, 32'd0,        32'd0,        1'b0, 1'b0, 34, 33};
    vecs[11] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'd1,        32'd0,        1'b0, 1'b0, 34, 33};
    vecs[12] = '{32'h80000000, 32'd2,        1'b1, 32'hC0000000, 32'd0,        1'b0, 1'b0, 34, 33};
    vecs[13] = '{32'h80000005, 32'd0,        1'b1, 32'hFFFFFFFF, 32'h80000005, 1'b1, 1'b0, 2,  0};
    vecs[14] = '{32'd7,        32'hFFFFFFFF, 1'b1, 32'hFFFFFFF9, 32'd0,        1'b0, 1'b0, 34, 33};

    rst = 1'b1; start = 1'b0; is_signed = 1'b0; opA = '0; opB = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", W'(busy), '0);
    chk("rst_done", W'(done), '0);
    chk("rst_quot", quotient, '0);
    chk("rst_rem",  remainder, '0);
    chk("rst_dz",   W'(div_by_zero), '0);
    chk("rst_ov",   W'(overflow), '0);
    rst = 1'b0;
    @(negedge clk);

    // table-driven vectors
    for (int i = 0; i < 15; i++) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].s);
      wait_done(lat, bcy);
      chk($sformatf("v%0d_lat", i), W'(lat), W'(vecs[i].lat));
      chk($sformatf("v%0d_busy_cycles", i), W'(bcy), W'(vecs[i].bcy));
      chk_result($sformatf("v%0d", i), vecs[i]);
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse", i), W'(done), '0);
      chk($sformatf("v%0d_held_quot", i), quotient, vecs[i].q);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // start while busy is ignored
    issue(32'd100, 32'd7, 1'b0);
    repeat (3) @(negedge clk);
    opA = 32'd50; opB = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bcy);
    v = '{32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 1'b0, 0, 0};
    chk_result("busy_ignore", v);
    @(negedge clk);
    @(negedge clk);
    chk("busy_ignore_idle", W'(busy), '0);

    // start in the DONE cycle: back-to-back
    issue(32'd20, 32'd3, 1'b0);
    wait_done(lat, bcy);
    v = '{32'd20, 32'd3, 1'b0, 32'd6, 32'd2, 1'b0, 1'b0, 0, 0};
    chk_result("b2b_first", v);
    issue(32'd45, 32'd6, 1'b0);
    wait_done(lat, bcy);
    chk("b2b_lat", W'(lat), 32'd34);
    v = '{32'd45, 32'd6, 1'b0, 32'd7, 32'd3, 1'b0, 1'b0, 0, 0};
    chk_result("b2b_second", v);
    @(negedge clk);

    // reset mid-RUN (prior results are nonzero)
    issue(32'd100, 32'd7, 1'b0);
    repeat (10) @(negedge clk);
    chk("mid_busy_before_rst", W'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", W'(busy), '0);
    chk("mid_rst_quot", quotient, '0);
    chk("mid_rst_rem",  remainder, '0);
    begin
      int seen_done = 0;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        if (done === 1'b1) seen_done++;
      end
      rst = 1'b0;
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        if (done === 1'b1) seen_done++;
      end
      chk("mid_rst_no_done", W'(seen_done), '0);
    end
    issue(32'hFFFFFFFF, 32'd1, 1'b0);
    wait_done(lat, bcy);
    chk("after_rst_lat", W'(lat), 32'd34);
    v = '{32'hFFFFFFFF, 32'd1, 1'b0, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b0, 0, 0};
    chk_result("after_rst", v);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_div.md
Name: seq_div

Overview:
Iterative restoring integer divider for the ALU. It is the inverse-operation companion to the combinational add/sub path and is the ALU's first multi-cycle unit.
- Accepts dividend/divisor with a start pulse.
- Resolves one quotient bit per clock.
- Returns quotient, remainder and status with a one-cycle done pulse.
- Supports signed (truncating) and unsigned division.

Parameters:
- WIDTH, 32: operand, quotient and remainder width in bits; legal range ≥ 4.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- is_signed  input  1  1 = two's-complement operands; 0 = unsigned. Captured with start.
- opA  input  WIDTH  dividend; captured with start.
- opB  input  WIDTH  divisor; captured with start.
- busy  output  1  high while a division is in progress.
- done  output  1  one-cycle pulse; results valid from this cycle.
- quotient  output  WIDTH  registered; held until next accepted start.
- remainder  output  WIDTH  registered; held until next accepted start.
- div_by_zero  output  1  registered status for the last result.
- overflow  output  1  registered; signed MIN / -1 only.

Behaviour:
- Reset (async, rst=1): state IDLE. busy, done, quotient, remainder, div_by_zero and overflow are all 0. Reset mid-operation aborts immediately; no done is produced.
- States:
  - IDLE: start=1 → capture inputs, clear status flags → RUN (or DONE if opB=0).
  - RUN: WIDTH iterations.
  - FIX: sign correction, results written.
  - DONE: done=1 for one cycle.
  - DONE → IDLE unconditionally; a start in DONE is accepted exactly as in IDLE.
- busy: 1 in RUN and FIX, 0 in IDLE and DONE. start while busy=1 is ignored.
- Capture cycle:
  - If is_signed=1, take magnitudes |opA| and |opB|.
  - Record q_neg = signA^signB and r_neg = signA.
  - |MIN| = 2^(WIDTH-1) as an unsigned value, so no special case is needed.
- RUN step, per cycle, MSB first:
  - Shift {rem, dvd} left by 1.
  - Trial = rem - divisor, computed on WIDTH+1 bits.
  - If trial ≥ 0: rem ← trial, quotient bit = 1; else quotient bit = 0.
  - Iteration counter runs 0..WIDTH-1 and exits to FIX on WIDTH-1.
- FIX:
  - quotient = q_neg ? -q : q.
  - remainder = r_neg ? -rem : rem.
  - Negation is modulo 2^WIDTH.
- Latency: start sampled at edge 0.
  - Normal: done is high in the cycle after edge WIDTH+1, i.e. WIDTH+2 cycles from request to result.
  - Divide-by-zero: done is high in the cycle after edge 1.
- Divide by zero (opB=0, either mode):
  - quotient = all ones, remainder = opA as given, div_by_zero=1.
  - RUN/FIX are skipped.
- Signed overflow (opA=MIN, opB=-1, is_signed=1):
  - Algorithm naturally yields quotient = MIN, remainder = 0.
  - overflow=1, normal latency.
- Invariants when div_by_zero=0: opA = quotient*opB + remainder (mod 2^WIDTH); |remainder| < |opB|; remainder sign = dividend sign or zero.
- Input changes after the start cycle have no effect on the running operation.

Decomposition:
- Shared ALU header/package holds:
  - State encodings: IDLE=2'd0, RUN=2'd1, FIX=2'd2, DONE=2'd3.
  - Counter width macro: clog2(WIDTH).
  - Divide-by-zero quotient constant.
- One natural sub-module, div_negate: parameterised conditional two's-complement negator (in, neg, out). Instantiated for operand magnitude and for result sign fix.

Test Plan:
1. Unsigned: opA=100, opB=7 → after 34 cycles, quotient=14, remainder=2, flags 0; busy high 33 cycles.
2. Signed: opA=-7, opB=2 → quotient=-3 (0xFFFFFFFD), remainder=-1 (0xFFFFFFFF); opA=7, opB=-2 → quotient=-3, remainder=1.
3. Divide by zero: opA=0x1234, opB=0 (either mode) → done 2 cycles after start; quotient=0xFFFFFFFF, remainder=0x1234, div_by_zero=1.
4. Signed overflow: opA=0x80000000, opB=0xFFFFFFFF → quotient=0x80000000, remainder=0, overflow=1. Same operands unsigned → quotient=0, remainder=0x80000000, overflow=0.
5. Handshake: start re-pulsed with new operands while busy → ignored, first result unchanged. Start asserted in the DONE cycle → accepted, back-to-back result correct.
6. Reset mid-RUN at iteration 10 → all outputs 0 immediately, no done pulse. Next start with 0xFFFFFFFF/1 unsigned → quotient=0xFFFFFFFF, remainder=0.
